// File: rtl/mpu_sample_sequencer_pkg.sv
// Shared types and constants for the MPU6050 sample sequencer.
package mpu_seq_pkg;

  localparam int unsigned NUM_BYTES = 14;
  localparam int unsigned SAMPLE_W  = 16;
  localparam int unsigned ADR_W     = 4;

  // Byte offsets of the burst, in register order ACCEL_XOUT_H..GYRO_ZOUT_L
  localparam int unsigned ACCEL_X_H = 0;
  localparam int unsigned ACCEL_X_L = 1;
  localparam int unsigned ACCEL_Y_H = 2;
  localparam int unsigned ACCEL_Y_L = 3;
  localparam int unsigned ACCEL_Z_H = 4;
  localparam int unsigned ACCEL_Z_L = 5;
  localparam int unsigned TEMP_H    = 6;
  localparam int unsigned TEMP_L    = 7;
  localparam int unsigned GYRO_X_H  = 8;
  localparam int unsigned GYRO_X_L  = 9;
  localparam int unsigned GYRO_Y_H  = 10;
  localparam int unsigned GYRO_Y_L  = 11;
  localparam int unsigned GYRO_Z_H  = 12;
  localparam int unsigned GYRO_Z_L  = 13;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

  typedef enum logic [1:0] {
    ST_COLLECT,
    ST_PUBLISH,
    ST_WAIT,
    ST_RESCAN
  } seq_state_t;

  // Big-endian byte pair to signed sample
  function automatic sample_t be_word(input logic [7:0] hi, input logic [7:0] lo);
    return sample_t'({hi, lo});
  endfunction

endpackage

// File: rtl/mpu_sample_sequencer_if.sv
// Byte-stream handshake between the MPU6050 instruction sequencer (master)
// and the sample sequencer (slave).
interface mpu_sample_sequencer_if;
  import mpu_seq_pkg::*;

  logic             LOAD;
  logic [ADR_W-1:0] ADR;
  logic [7:0]       DATA;
  logic             COMPLETED;
  logic             RESCAN;

  modport master (
    output LOAD, ADR, DATA, COMPLETED,
    input  RESCAN
  );

  modport slave (
    input  LOAD, ADR, DATA, COMPLETED,
    output RESCAN
  );

endinterface

// File: rtl/mpu_sample_sequencer_regfile.sv
// 14-byte burst store with per-byte valid mask; presents big-endian words.
module mpu_sample_regfile
  import mpu_seq_pkg::*;
(
  input  logic             MCLK,
  input  logic             nRST,
  input  logic             wr_en,
  input  logic [ADR_W-1:0] wr_idx,
  input  logic [7:0]       wr_data,
  input  logic             mask_clr,
  output sample_t          ax,
  output sample_t          ay,
  output sample_t          az,
  output sample_t          temp,
  output sample_t          gx,
  output sample_t          gy,
  output sample_t          gz,
  output logic             mask_full
);

  logic [7:0]           byte_q [NUM_BYTES];
  logic [NUM_BYTES-1:0] mask_q;
  logic [NUM_BYTES-1:0] wr_bit;

  // One-hot write select; indices 14 and 15 match no byte and are dropped
  always_comb begin
    wr_bit = '0;
    for (int unsigned i = 0; i < NUM_BYTES; i++) begin
      wr_bit[i] = wr_en && (wr_idx == ADR_W'(i));
    end
  end

  // Byte capture and mask accumulation; clear takes priority over a write
  always_ff @(posedge MCLK or negedge nRST) begin
    if (!nRST) begin
      for (int unsigned i = 0; i < NUM_BYTES; i++) begin
        byte_q[i] <= '0;
      end
      mask_q <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_BYTES; i++) begin
        if (wr_bit[i]) begin
          byte_q[i] <= wr_data;
        end
      end
      mask_q <= mask_clr ? '0 : (mask_q | wr_bit);
    end
  end

  // Includes the write of this cycle so a last byte arriving together with
  // COMPLETED still counts toward a full burst.
  assign mask_full = &(mask_q | wr_bit);

  assign ax   = be_word(byte_q[ACCEL_X_H], byte_q[ACCEL_X_L]);
  assign ay   = be_word(byte_q[ACCEL_Y_H], byte_q[ACCEL_Y_L]);
  assign az   = be_word(byte_q[ACCEL_Z_H], byte_q[ACCEL_Z_L]);
  assign temp = be_word(byte_q[TEMP_H],    byte_q[TEMP_L]);
  assign gx   = be_word(byte_q[GYRO_X_H],  byte_q[GYRO_X_L]);
  assign gy   = be_word(byte_q[GYRO_Y_H],  byte_q[GYRO_Y_L]);
  assign gz   = be_word(byte_q[GYRO_Z_H],  byte_q[GYRO_Z_L]);

endmodule

// File: rtl/mpu_sample_sequencer.sv
// Schedules periodic MPU6050 burst reads, collects the 14 streamed bytes and
// publishes seven signed samples with a one-cycle valid strobe.
module mpu_sample_sequencer
  import mpu_seq_pkg::*;
#(
  parameter int unsigned PERIOD_CYC  = 500000,
  parameter int unsigned TIMEOUT_CYC = 2500000
) (
  input  logic                        MCLK,
  input  logic                        nRST,
  input  logic                        ENABLE,
  mpu_sample_sequencer_if.slave       src,
  output sample_t                     AX,
  output sample_t                     AY,
  output sample_t                     AZ,
  output sample_t                     TEMP,
  output sample_t                     GX,
  output sample_t                     GY,
  output sample_t                     GZ,
  output logic                        SAMPLE_VALID,
  output logic [7:0]                  SAMPLE_CNT,
  output logic                        BUSY,
  output logic                        ERR_TIMEOUT,
  output logic                        ERR_SHORT,
  input  logic                        ERR_CLR
);

  localparam int unsigned PW = $clog2(PERIOD_CYC + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

  seq_state_t    state_q, state_d;
  logic [PW-1:0] period_cnt;
  logic [TW-1:0] to_cnt;

  logic    to_last;
  logic    wait_done;
  logic    set_short;
  logic    set_timeout;
  logic    publish;
  logic    wr_en;
  logic    mask_clr;
  logic    mask_full;
  logic    rescan;
  sample_t rf_ax, rf_ay, rf_az, rf_temp, rf_gx, rf_gy, rf_gz;

  assign to_last   = (to_cnt == TW'(TIMEOUT_CYC - 1));
  assign wait_done = (period_cnt <= PW'(1));

  mpu_sample_regfile u_regfile (
    .MCLK      (MCLK),
    .nRST      (nRST),
    .wr_en     (wr_en),
    .wr_idx    (src.ADR),
    .wr_data   (src.DATA),
    .mask_clr  (mask_clr),
    .ax        (rf_ax),
    .ay        (rf_ay),
    .az        (rf_az),
    .temp      (rf_temp),
    .gx        (rf_gx),
    .gy        (rf_gy),
    .gz        (rf_gz),
    .mask_full (mask_full)
  );

  // State register
  always_ff @(posedge MCLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= ST_COLLECT;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; burst completion and handshake release beat a timeout
  always_comb begin
    state_d     = state_q;
    set_short   = 1'b0;
    set_timeout = 1'b0;
    unique case (state_q)
      ST_COLLECT: begin
        if (src.COMPLETED) begin
          if (mask_full) begin
            state_d = ST_PUBLISH;
          end else begin
            set_short = 1'b1;
            state_d   = ST_WAIT;
          end
        end else if (to_last) begin
          set_timeout = 1'b1;
          state_d     = ST_WAIT;
        end
      end
      ST_PUBLISH: state_d = ST_WAIT;
      ST_WAIT: begin
        if (ENABLE && wait_done) begin
          state_d = ST_RESCAN;
        end
      end
      ST_RESCAN: begin
        if (!src.COMPLETED) begin
          state_d = ST_COLLECT;
        end else if (to_last) begin
          set_timeout = 1'b1;
          state_d     = ST_WAIT;
        end
      end
      default: state_d = ST_COLLECT;
    endcase
  end

  // State-decoded outputs and datapath controls
  always_comb begin
    rescan   = (state_q == ST_RESCAN);
    BUSY     = (state_q == ST_COLLECT) || (state_q == ST_RESCAN);
    publish  = (state_q == ST_PUBLISH);
    wr_en    = (state_q == ST_COLLECT) && src.LOAD;
    mask_clr = publish || set_short || set_timeout;
  end

  assign src.RESCAN = rescan;

  // Handshake timeout counter: zero on entry to COLLECT/RESCAN, counts while there
  always_ff @(posedge MCLK or negedge nRST) begin
    if (!nRST) begin
      to_cnt <= '0;
    end else if ((state_d == state_q) &&
                 ((state_d == ST_COLLECT) || (state_d == ST_RESCAN))) begin
      to_cnt <= to_cnt + TW'(1);
    end else begin
      to_cnt <= '0;
    end
  end

  // Period counter: loaded when entering WAIT, counts down and parks at zero
  always_ff @(posedge MCLK or negedge nRST) begin
    if (!nRST) begin
      period_cnt <= '0;
    end else if (publish || set_short || set_timeout) begin
      period_cnt <= PW'(PERIOD_CYC);
    end else if ((state_q == ST_WAIT) && (period_cnt != '0)) begin
      period_cnt <= period_cnt - PW'(1);
    end
  end

  // Sample outputs, valid strobe and publish counter
  always_ff @(posedge MCLK or negedge nRST) begin
    if (!nRST) begin
      AX           <= '0;
      AY           <= '0;
      AZ           <= '0;
      TEMP         <= '0;
      GX           <= '0;
      GY           <= '0;
      GZ           <= '0;
      SAMPLE_VALID <= 1'b0;
      SAMPLE_CNT   <= '0;
    end else begin
      SAMPLE_VALID <= publish;
      if (publish) begin
        AX         <= rf_ax;
        AY         <= rf_ay;
        AZ         <= rf_az;
        TEMP       <= rf_temp;
        GX         <= rf_gx;
        GY         <= rf_gy;
        GZ         <= rf_gz;
        SAMPLE_CNT <= SAMPLE_CNT + 8'd1;
      end
    end
  end

  // Sticky error flags; a new error wins over a clear in the same cycle
  always_ff @(posedge MCLK or negedge nRST) begin
    if (!nRST) begin
      ERR_TIMEOUT <= 1'b0;
      ERR_SHORT   <= 1'b0;
    end else begin
      if (set_timeout) begin
        ERR_TIMEOUT <= 1'b1;
      end else if (ERR_CLR) begin
        ERR_TIMEOUT <= 1'b0;
      end
      if (set_short) begin
        ERR_SHORT <= 1'b1;
      end else if (ERR_CLR) begin
        ERR_SHORT <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mpu_sample_sequencer.sv
// Directed bench for mpu_sample_sequencer with PERIOD_CYC=8, TIMEOUT_CYC=20.
module tb_mpu_sample_sequencer;
  import mpu_seq_pkg::*;

  logic       MCLK;
  logic       nRST;
  logic       ENABLE;
  logic       ERR_CLR;
  sample_t    AX, AY, AZ, TEMP, GX, GY, GZ;
  logic       SAMPLE_VALID;
  logic [7:0] SAMPLE_CNT;
  logic       BUSY;
  logic       ERR_TIMEOUT;
  logic       ERR_SHORT;

  int errors = 0;
  int checks = 0;

  logic [3:0] la [16];
  logic [7:0] ld [16];

  mpu_sample_sequencer_if src_if();

  mpu_sample_sequencer #(
    .PERIOD_CYC  (8),
    .TIMEOUT_CYC (20)
  ) dut (
    .MCLK         (MCLK),
    .nRST         (nRST),
    .ENABLE       (ENABLE),
    .src          (src_if),
    .AX           (AX),
    .AY           (AY),
    .AZ           (AZ),
    .TEMP         (TEMP),
    .GX           (GX),
    .GY           (GY),
    .GZ           (GZ),
    .SAMPLE_VALID (SAMPLE_VALID),
    .SAMPLE_CNT   (SAMPLE_CNT),
    .BUSY         (BUSY),
    .ERR_TIMEOUT  (ERR_TIMEOUT),
    .ERR_SHORT    (ERR_SHORT),
    .ERR_CLR      (ERR_CLR)
  );

  initial MCLK = 1'b0;
  always #5 MCLK = ~MCLK;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next active edge
  task automatic step();
    @(posedge MCLK);
    #1;
  endtask

  // Bytes base+0..base+13 on ADR 0..13
  task automatic fill_std(input logic [7:0] base);
    for (int i = 0; i < 14; i++) begin
      la[i] = 4'(i);
      ld[i] = base + 8'(i);
    end
  endtask

  // Stream n loads; COMPLETED rises together with the last one
  task automatic do_loads(input int n);
    for (int i = 0; i < n; i++) begin
      src_if.LOAD      = 1'b1;
      src_if.ADR       = la[i];
      src_if.DATA      = ld[i];
      src_if.COMPLETED = (i == n - 1);
      step();
    end
    src_if.LOAD = 1'b0;
    src_if.ADR  = '0;
    src_if.DATA = '0;
  endtask

  task automatic wait_rescan(input string tag);
    int n;
    n = 0;
    while (src_if.RESCAN !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    chk(tag, 16'(src_if.RESCAN), 16'h1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int rescan_seen;
    int bad_valid;

    nRST             = 1'b0;
    ENABLE           = 1'b1;
    ERR_CLR          = 1'b0;
    src_if.LOAD      = 1'b0;
    src_if.ADR       = '0;
    src_if.DATA      = '0;
    src_if.COMPLETED = 1'b0;
    repeat (3) step();

    chk("rst_rescan", 16'(src_if.RESCAN), 16'h0);
    chk("rst_valid",  16'(SAMPLE_VALID), 16'h0);
    chk("rst_busy",   16'(BUSY), 16'h1);
    chk("rst_ax",     AX, 16'h0000);
    chk("rst_gz",     GZ, 16'h0000);
    chk("rst_cnt",    16'(SAMPLE_CNT), 16'h0);
    chk("rst_errt",   16'(ERR_TIMEOUT), 16'h0);
    chk("rst_errs",   16'(ERR_SHORT), 16'h0);
    nRST = 1'b1;

    // Good burst 0x01..0x0E
    fill_std(8'h01);
    do_loads(14);
    chk("pub_cycle_valid", 16'(SAMPLE_VALID), 16'h0);
    step();
    chk("b1_valid", 16'(SAMPLE_VALID), 16'h1);
    chk("b1_ax",   AX,   16'h0102);
    chk("b1_ay",   AY,   16'h0304);
    chk("b1_az",   AZ,   16'h0506);
    chk("b1_temp", TEMP, 16'h0708);
    chk("b1_gx",   GX,   16'h090A);
    chk("b1_gy",   GY,   16'h0B0C);
    chk("b1_gz",   GZ,   16'h0D0E);
    chk("b1_cnt",  16'(SAMPLE_CNT), 16'h1);
    chk("b1_busy", 16'(BUSY), 16'h0);

    // Period of 8 WAIT cycles, then handshake held by COMPLETED
    repeat (7) step();
    chk("b1_valid_pulse", 16'(SAMPLE_VALID), 16'h0);
    chk("per_early", 16'(src_if.RESCAN), 16'h0);
    step();
    chk("per_rise", 16'(src_if.RESCAN), 16'h1);
    repeat (3) step();
    chk("hold_rescan", 16'(src_if.RESCAN), 16'h1);
    chk("hold_busy",   16'(BUSY), 16'h1);
    src_if.COMPLETED = 1'b0;
    step();
    chk("rescan_fall", 16'(src_if.RESCAN), 16'h0);
    chk("collect_busy", 16'(BUSY), 16'h1);

    // Short burst: ADR 0..12 plus an out-of-range ADR 14, no ADR 13
    fill_std(8'hA0);
    la[13] = 4'd14;
    do_loads(14);
    chk("short_err",   16'(ERR_SHORT), 16'h1);
    chk("short_valid", 16'(SAMPLE_VALID), 16'h0);
    chk("short_busy",  16'(BUSY), 16'h0);
    chk("short_ax",    AX, 16'h0102);
    chk("short_gz",    GZ, 16'h0D0E);
    chk("short_cnt",   16'(SAMPLE_CNT), 16'h1);
    ERR_CLR = 1'b1;
    step();
    ERR_CLR = 1'b0;
    chk("short_valid2", 16'(SAMPLE_VALID), 16'h0);
    chk("short_clr",    16'(ERR_SHORT), 16'h0);
    chk("short_ax2",    AX, 16'h0102);
    wait_rescan("short_retry_rescan");
    src_if.COMPLETED = 1'b0;
    step();

    // Timeout in COLLECT; ERR_CLR in the setting cycle loses
    repeat (19) step();
    chk("to_early",      16'(ERR_TIMEOUT), 16'h0);
    chk("to_early_busy", 16'(BUSY), 16'h1);
    ERR_CLR = 1'b1;
    step();
    ERR_CLR = 1'b0;
    chk("to_set",  16'(ERR_TIMEOUT), 16'h1);
    chk("to_busy", 16'(BUSY), 16'h0);
    chk("to_cnt",  16'(SAMPLE_CNT), 16'h1);
    repeat (7) step();
    chk("to_per_early", 16'(src_if.RESCAN), 16'h0);
    step();
    chk("to_per_rise", 16'(src_if.RESCAN), 16'h1);
    step();
    chk("to_rescan_fall", 16'(src_if.RESCAN), 16'h0);
    chk("to_collect",     16'(BUSY), 16'h1);
    chk("to_sticky",      16'(ERR_TIMEOUT), 16'h1);
    ERR_CLR = 1'b1;
    step();
    ERR_CLR = 1'b0;
    chk("to_clr", 16'(ERR_TIMEOUT), 16'h0);

    // ENABLE low during a burst with an overwritten byte and negative GX
    ENABLE = 1'b0;
    la[0] = 4'd0;
    ld[0] = 8'h55;
    for (int i = 0; i < 14; i++) begin
      la[i + 1] = 4'(i);
      ld[i + 1] = 8'h10 + 8'(i);
    end
    ld[9]  = 8'hFF;
    ld[10] = 8'h38;
    do_loads(15);
    step();
    chk("en_valid", 16'(SAMPLE_VALID), 16'h1);
    chk("en_ax",    AX, 16'h1011);
    chk("en_gx",    GX, 16'hFF38);
    chk("en_gz",    GZ, 16'h1C1D);
    chk("en_cnt",   16'(SAMPLE_CNT), 16'h2);
    rescan_seen = 0;
    repeat (30) begin
      step();
      if (src_if.RESCAN === 1'b1) rescan_seen++;
    end
    chk("en_park_rescan", 16'(rescan_seen), 16'h0);
    chk("en_park_busy",   16'(BUSY), 16'h0);
    ENABLE = 1'b1;
    step();
    chk("en_resume", 16'(src_if.RESCAN), 16'h1);
    src_if.COMPLETED = 1'b0;
    step();

    // Run the publish counter round to wrap
    bad_valid = 0;
    for (int k = 0; k < 254; k++) begin
      fill_std(8'(k));
      do_loads(14);
      step();
      if (SAMPLE_VALID !== 1'b1) bad_valid++;
      if (k == 252) chk("cnt_255", 16'(SAMPLE_CNT), 16'h00FF);
      if (k == 253) begin
        chk("cnt_wrap", 16'(SAMPLE_CNT), 16'h0000);
        chk("wrap_ax",  AX, 16'hFDFE);
        chk("wrap_gz",  GZ, 16'h090A);
      end
      wait_rescan("loop_rescan");
      src_if.COMPLETED = 1'b0;
      step();
    end
    chk("loop_valid", 16'(bad_valid), 16'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mpu_sample_sequencer.md
# mpu_sample_sequencer

Controller that schedules periodic MPU6050 burst reads and assembles the result. It drives RESCAN toward the MPU6050 instruction sequencer and captures the 14 streamed register bytes (ACCEL_XOUT_H..GYRO_ZOUT_L) from its LOAD/ADR/DATA outputs. It then publishes seven signed 16-bit samples with a one-cycle valid strobe. It sits between the MPU6050 sequencer and the application logic (display/game logic) and owns sample rate, retry and error reporting.

## Interface
- PERIOD_CYC, 500000 — MCLK cycles from one publish to the next RESCAN request (10 ms at 50 MHz); minimum 1.
- TIMEOUT_CYC, 2500000 — MCLK cycles allowed in COLLECT or RESCAN handshake before abort.
- MCLK  in  1  system clock.
- nRST  in  1  reset, asynchronous, active-low.
- ENABLE  in  1  1 = schedule rescans; 0 = park in WAIT after the current read.
- LOAD  in  1  one-cycle strobe per received byte, from MPU6050 sequencer.
- ADR  in  4  byte index 0..13 accompanying LOAD.
- DATA  in  8  byte value accompanying LOAD.
- COMPLETED  in  1  source finished a burst; held high until it restarts.
- RESCAN  out  1  restart request to source, level.
- AX, AY, AZ, TEMP, GX, GY, GZ  out  16 each  signed samples, big-endian pairs.
- SAMPLE_VALID  out  1  one-cycle pulse when outputs update.
- SAMPLE_CNT  out  8  published-sample counter, wraps 255→0.
- BUSY  out  1  high in COLLECT and RESCAN.
- ERR_TIMEOUT, ERR_SHORT  out  1 each  sticky error flags.
- ERR_CLR  in  1  synchronous clear of both sticky flags.

## Operation
- States: COLLECT, PUBLISH, WAIT, RESCAN. Reset state is COLLECT, because the source self-starts after reset.
- COLLECT:
  - LOAD=1 with ADR<14 writes DATA into byte[ADR] and sets mask[ADR].
  - LOAD with ADR≥14 is ignored.
  - A repeated ADR overwrites the byte; the mask bit stays set.
- COLLECT exit on COLLECTED rising to 1, i.e. on COMPLETED=1:
  - mask all ones → PUBLISH.
  - otherwise → set ERR_SHORT, clear mask, go to WAIT; outputs are unchanged.
- PUBLISH (1 cycle):
  - Register outputs: AX={b0,b1}, AY={b2,b3}, AZ={b4,b5}, TEMP={b6,b7}, GX={b8,b9}, GY={b10,b11}, GZ={b12,b13}.
  - Pulse SAMPLE_VALID, increment SAMPLE_CNT, clear mask, load period counter.
  - Then → WAIT.
- WAIT: count down PERIOD_CYC. At zero with ENABLE=1 → RESCAN. ENABLE=0 holds WAIT with the counter frozen at zero.
- RESCAN: RESCAN=1 until COMPLETED=0 is sampled, then RESCAN=0 → COLLECT.
- Timeout: a counter restarts on entry to COLLECT/RESCAN. Reaching TIMEOUT_CYC sets ERR_TIMEOUT, clears mask, goes to WAIT; this is a retry after the period.
- ERR_CLR is applied in the same cycle as a new error set: the set wins.

## Timing
- Reset values:
  - RESCAN=0, SAMPLE_VALID=0, BUSY=1 (COLLECT).
  - All samples 16'h0000, SAMPLE_CNT=0, both error flags=0, mask=0, counters=0.
- A byte is captured on the MCLK edge where LOAD=1; mask is visible the next cycle.
- A LOAD coinciding with COMPLETED's first high cycle is captured before the mask test.
- Publish latency:
  - COMPLETED sampled high → PUBLISH next cycle.
  - Outputs and SAMPLE_VALID are valid the cycle after that (2 cycles).
  - Outputs hold until the next PUBLISH.
- RESCAN rises the cycle after WAIT expires, and falls the cycle after COMPLETED=0 is sampled.
- Sample period = PERIOD_CYC + handshake + burst duration; it is not phase-locked.
- Asynchronous reset mid-burst discards partial bytes. The sequencer re-enters COLLECT and relies on the source's own reset.

## Structure
- Package mpu_seq_pkg:
  - NUM_BYTES=14 and the state enum.
  - Byte-offset constants (ACCEL_X_H=0 … GYRO_Z_L=13).
  - Sample width 16.
- One sub-module, mpu_sample_regfile: 14×8 byte store plus 14-bit mask. Inputs are write strobe/index/data and mask clear; outputs are the concatenated 16-bit words and mask_full.
- The top level holds the FSM, both counters and the error flags.

## Test plan
- Reset, then bytes 0x01..0x0E on ADR 0..13, then COMPLETED → SAMPLE_VALID two cycles later; AX=0x0102 … GZ=0x0D0E, SAMPLE_CNT=1.
- Only ADR 0..12 loaded, then COMPLETED → ERR_SHORT=1, no SAMPLE_VALID, outputs keep the previous values. After ERR_CLR, ERR_SHORT=0.
- PERIOD_CYC=8 after a publish → RESCAN rises after 8 cycles in WAIT. Holding COMPLETED high keeps RESCAN high; dropping COMPLETED drops RESCAN next cycle, and BUSY=1.
- TIMEOUT_CYC=20 with no COMPLETED → ERR_TIMEOUT at cycle 20, state WAIT, then RESCAN after the period.
- ENABLE=0 during COLLECT → the burst still publishes, then RESCAN stays 0 indefinitely. ENABLE=1 → RESCAN next cycle.
- 256 consecutive good bursts → SAMPLE_CNT wraps to 0. GX bytes 0xFF,0x38 publish GX=0xFF38 (−200).
